hsem_ahb_top: RTL and testbench
===============================

// Module: hsem_ahb_top
// PURPOSE
// - AHB-Lite slave hardware semaphore block arbitrating 4 shared resources between two cores (core 0, core 1).
// - Each core locks/releases a semaphore through its own per-core register alias.
// - Per-core error flags and per-core release interrupts (intr_0, intr_1) support waiting without polling.
// - Sits on the system AHB bus; reference base address 0x10002000; decodes haddr[7:0] only, hsel selects the block.
// PARAMETERS
// - SEM_NUM  4   number of semaphores; only 4 is supported by the register map
// PORTS
// - hclk       in   1   clock; every flop on rising edge
// - hresetn    in   1   reset, asynchronous, active-low
// - hsel       in   1   slave select
// - hready     in   1   bus ready-in; address phase accepted only when 1
// - hburst     in   3   unused (single transfers only)
// - hmastlock  in   1   unused
// - hprot      in   4   unused
// - htrans     in   2   only htrans[1] used (NONSEQ/SEQ = valid)
// - hsize      in   3   unused; all accesses are 32-bit
// - hwrite     in   1   1 = write, 0 = read
// - haddr      in   32  byte address; offset = haddr[7:0]
// - hwdata     in   32  write data, valid in data phase
// - hreadyout  out  1   constant 1 (zero wait states)
// - hresp      out  2   constant 2'b00 (OKAY), including unmapped offsets
// - hrdata     out  32  read data in data phase
// - intr_0     out  1   core 0 interrupt = |INT_STAT[3:0] (masked if enabled)
// - intr_1     out  1   core 1 interrupt = |INT_STAT[7:4] (masked if enabled)
// BEHAVIOUR
// - Address phase accepted when hsel & hready & htrans[1]; register haddr[7:0] and hwrite, then set a data-phase valid flag.
// - Writes commit at the clock edge that ends the data phase, using hwdata.
// - Reads: hrdata is combinational from the latched offset during the data phase, and 0 otherwise.
// - A read that directly follows a write sees the updated value.
// - Register map:
//   - 0x00+8n (n=0..3) LOCK0_n, core 0 alias; 0x04+8n LOCK1_n, core 1 alias.
//   - LOCKc_n write: hwdata[0]=1 is a lock request, hwdata[0]=0 is a release; other bits ignored.
//   - LOCKc_n read: {30'b0, owner, locked}.
//   - 0x20 INT_STAT RO: bit n set when core 1 releases sem n (notifies core 0); bit 4+n set when core 0 releases sem n (notifies core 1).
//   - 0x24 INT_CLR: a read returns INT_STAT and clears it; a write clears the bits where hwdata=1.
//   - 0x28 ERR RO: bit n = core 0 error on sem n; bit 4+n = core 1 error on sem n.
//   - 0x2C ERR_CLR: a read returns ERR and clears it; a write clears the bits where hwdata=1.
//   - 0x30+4n SEM_STAT_n RO: {30'b0, owner, locked}.
//   - Other offsets: reads return 0, writes are ignored, hresp stays OKAY.
// - Lock request by core c on sem n:
//   - Free: locked=1, owner=c.
//   - Already owned by c: no change.
//   - Owned by the other core: no change, ERR[4c+n] set.
// - Release by core c on sem n:
//   - Owned by c: locked=0, owner=0, and the other core's INT_STAT bit for n is set.
//   - Free or owned by the other core: no state change, ERR[4c+n] set.
// - If a set and a clear of the same INT_STAT/ERR bit occur in the same cycle, the set wins.
// - Reset: all semaphores free, owner=0, INT_STAT=0, ERR=0, INT_EN=0, data-phase flag=0, hrdata=0, intr_0=intr_1=0.
// - If reset is asserted mid-transfer, the pending data phase is discarded.
// CONFIGURATION
// - Macro HSEM_INT_MASK_EN (defined in sem_config.v).
// - Defined:
//   - Offset 0x40 is INT_EN, RW, bits[7:0], reset value 0.
//   - intr_0 = |(INT_STAT[3:0] & INT_EN[3:0]); intr_1 = |(INT_STAT[7:4] & INT_EN[7:4]).
//   - INT_STAT still records events while they are masked.
// - Not defined:
//   - 0x40 is unmapped: reads return 0 and writes are ignored.
//   - intr_0/intr_1 are the unmasked OR of their INT_STAT halves.
// TESTING
// - Reset, then read 0x00..0x44 -> all return 0; hreadyout=1, hresp=00 throughout; intr_0=intr_1=0.
// - Write 0x00=1, then read 0x30 -> 0x1.
// - Write 0x00=0xAA00 (release) -> INT_STAT=0x10, intr_1=1, intr_0=0, ERR=0.
// - Core 0 locks sem 0 (0x00=1), then core 1 writes 0x04=1 -> 0x30 reads 0x1, 0x28 reads 0x10; read 0x2C -> 0x10, then 0x28 reads 0.
// - Core 1 releases sem 0 while core 0 holds it -> ERR=0x10, semaphore still held.
// - Core 0 then releases sem 0 -> INT_STAT=0x10; read 0x24 -> 0x10, then INT_STAT=0 and intr_1=0.
// - Back-to-back: write 0x08=1, then immediately read 0x34 -> 0x1.
// - Write 0x0C=1 -> 0x34 still 0x1, ERR bit 5 set.
// - HSEM_INT_MASK_EN defined: INT_EN=0 with a release -> INT_STAT set but intr low.
// - Then write 0x40=0xFF -> intr asserts on the next cycle.

Source files
------------

// File: rtl/hsem_ahb_top.sv
// AHB-Lite hardware semaphore block: 4 semaphores shared by two cores, per-core lock aliases,
// error flags and release interrupts. Optional macro HSEM_INT_MASK_EN (sem_config.v) adds INT_EN at 0x40.
module hsem_ahb_top #(
   parameter int SEM_NUM = 4
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic        hready,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   output logic        hreadyout,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata,
   output logic        intr_0,
   output logic        intr_1
);

   typedef enum logic [2:0] {
      R_LOCK, R_INT_STAT, R_INT_CLR, R_ERR, R_ERR_CLR, R_SEM_STAT, R_INT_EN, R_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode(input logic [7:0] off);
      reg_sel_e sel;
      sel = R_NONE;
      if (off[7:5] == 3'b000)
         sel = R_LOCK;
      else if (off[7:4] == 4'h3)
         sel = R_SEM_STAT;
      else begin
         case (off[7:2])
            6'h08:   sel = R_INT_STAT;
            6'h09:   sel = R_INT_CLR;
            6'h0A:   sel = R_ERR;
            6'h0B:   sel = R_ERR_CLR;
`ifdef HSEM_INT_MASK_EN
            6'h10:   sel = R_INT_EN;
`endif
            default: sel = R_NONE;
         endcase
      end
      return sel;
   endfunction

   // Address-phase capture
   logic        dphase_q;
   logic        write_q;
   logic [7:0]  addr_q;
   logic        accept;

   // Semaphore and status state
   logic [SEM_NUM-1:0]   locked_q, locked_n;
   logic [SEM_NUM-1:0]   owner_q, owner_n;
   logic [2*SEM_NUM-1:0] int_stat_q, int_set, int_clr;
   logic [2*SEM_NUM-1:0] err_q, err_set, err_clr;
   logic [2*SEM_NUM-1:0] int_en;

   reg_sel_e    sel;
   logic [1:0]  lock_idx;
   logic [1:0]  stat_idx;
   logic        core;

   assign accept    = hsel & hready & htrans[1];
   assign hreadyout = 1'b1;
   assign hresp     = 2'b00;

   assign sel      = decode(addr_q);
   assign lock_idx = addr_q[4:3];
   assign stat_idx = addr_q[3:2];
   assign core     = addr_q[2];

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dphase_q <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
      end else begin
         dphase_q <= accept;
         if (accept) begin
            write_q <= hwrite;
            addr_q  <= haddr[7:0];
         end
      end
   end

   // NOTE: every variable is given a default before the case, so no latch can be inferred.
   always_comb begin
      locked_n = locked_q;
      owner_n  = owner_q;
      int_set  = '0;
      int_clr  = '0;
      err_set  = '0;
      err_clr  = '0;
      if (dphase_q) begin
         if (write_q) begin
            case (sel)
               R_LOCK: begin
                  if (hwdata[0]) begin
                     if (!locked_q[lock_idx]) begin
                        locked_n[lock_idx] = 1'b1;
                        owner_n[lock_idx]  = core;
                     end else if (owner_q[lock_idx] != core) begin
                        err_set[{core, lock_idx}] = 1'b1;
                     end
                  end else begin
                     if (locked_q[lock_idx] && (owner_q[lock_idx] == core)) begin
                        locked_n[lock_idx] = 1'b0;
                        owner_n[lock_idx]  = 1'b0;
                        // The release notifies the other core
                        int_set[{~core, lock_idx}] = 1'b1;
                     end else begin
                        err_set[{core, lock_idx}] = 1'b1;
                     end
                  end
               end
               R_INT_CLR: int_clr = hwdata[2*SEM_NUM-1:0];
               R_ERR_CLR: err_clr = hwdata[2*SEM_NUM-1:0];
               default:   ;
            endcase
         end else begin
            case (sel)
               R_INT_CLR: int_clr = '1;
               R_ERR_CLR: err_clr = '1;
               default:   ;
            endcase
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         locked_q   <= '0;
         owner_q    <= '0;
         int_stat_q <= '0;
         err_q      <= '0;
      end else begin
         locked_q   <= locked_n;
         owner_q    <= owner_n;
         // A set in the same cycle as a clear wins
         int_stat_q <= (int_stat_q & ~int_clr) | int_set;
         err_q      <= (err_q & ~err_clr) | err_set;
      end
   end

`ifdef HSEM_INT_MASK_EN
   logic [2*SEM_NUM-1:0] int_en_q;
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)
         int_en_q <= '0;
      else if (dphase_q && write_q && (sel == R_INT_EN))
         int_en_q <= hwdata[2*SEM_NUM-1:0];
   end
   assign int_en = int_en_q;
`else
   assign int_en = '1;
`endif

   assign intr_0 = |(int_stat_q[SEM_NUM-1:0] & int_en[SEM_NUM-1:0]);
   assign intr_1 = |(int_stat_q[2*SEM_NUM-1:SEM_NUM] & int_en[2*SEM_NUM-1:SEM_NUM]);

   always_comb begin
      hrdata = '0;
      if (dphase_q && !write_q) begin
         case (sel)
            R_LOCK:     hrdata = {30'b0, owner_q[lock_idx], locked_q[lock_idx]};
            R_SEM_STAT: hrdata = {30'b0, owner_q[stat_idx], locked_q[stat_idx]};
            R_INT_STAT,
            R_INT_CLR:  hrdata = {24'b0, int_stat_q};
            R_ERR,
            R_ERR_CLR:  hrdata = {24'b0, err_q};
            R_INT_EN:   hrdata = {24'b0, int_en};
            default:    hrdata = '0;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, hburst, hmastlock, hprot, htrans[0], hsize,
                        haddr[31:8], hwdata[31:2*SEM_NUM]};

endmodule

// File: tb/tb_hsem_ahb_top.sv
// Self-checking bench for hsem_ahb_top: directed register-map scenarios plus randomized
// accesses checked against a semaphore ownership model.
module tb_hsem_ahb_top;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic        hsel = 1'b0;
   logic        hready = 1'b1;
   logic [2:0]  hburst = '0;
   logic        hmastlock = 1'b0;
   logic [3:0]  hprot = '0;
   logic [1:0]  htrans = '0;
   logic [2:0]  hsize = 3'b010;
   logic        hwrite = 1'b0;
   logic [31:0] haddr = '0;
   logic [31:0] hwdata = '0;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        intr_0, intr_1;

   int n_checks = 0;
   int n_pass = 0;

   hsem_ahb_top dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready(hready), .hburst(hburst),
      .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hsize(hsize),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout),
      .hresp(hresp), .hrdata(hrdata), .intr_0(intr_0), .intr_1(intr_1)
   );

   always #5 hclk = ~hclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference model: owner per semaphore (-1 = free), event/error bytes, enable byte
   int         m_owner[4];
   logic [7:0] m_int, m_err, m_en;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_owner[i] = -1;
      m_int = '0; m_err = '0; m_en = '0;
   endfunction

   function automatic logic [31:0] sem_word(input int n);
      return (m_owner[n] < 0) ? 32'h0 : 32'(m_owner[n] * 2 + 1);
   endfunction

   // Applies one accepted access; returns the value a read must see
   function automatic logic [31:0] model(input bit w, input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd;
      int n, c;
      rd = '0;
      if (off < 8'h20) begin
         n = int'(off) / 8;
         c = (int'(off) % 8) / 4;
         if (!w) rd = sem_word(n);
         else if (d[0]) begin
            if (m_owner[n] < 0) m_owner[n] = c;
            else if (m_owner[n] != c) m_err[4*c+n] = 1'b1;
         end else begin
            if (m_owner[n] == c) begin
               m_owner[n] = -1;
               m_int[4*(1-c)+n] = 1'b1;
            end else m_err[4*c+n] = 1'b1;
         end
      end else if (off >= 8'h30 && off < 8'h40) begin
         if (!w) rd = sem_word((int'(off) - 'h30) / 4);
      end else begin
         case (off)
            8'h20: if (!w) rd = {24'b0, m_int};
            8'h24: if (!w) begin rd = {24'b0, m_int}; m_int = '0; end
                   else m_int &= ~d[7:0];
            8'h28: if (!w) rd = {24'b0, m_err};
            8'h2C: if (!w) begin rd = {24'b0, m_err}; m_err = '0; end
                   else m_err &= ~d[7:0];
`ifdef HSEM_INT_MASK_EN
            8'h40: if (!w) rd = {24'b0, m_en}; else m_en = d[7:0];
`endif
            default: ;
         endcase
      end
      return rd;
   endfunction

   function automatic logic exp_intr(input int core);
      logic [7:0] en;
`ifdef HSEM_INT_MASK_EN
      en = m_en;
`else
      en = 8'hFF;
`endif
      return core == 0 ? |(m_int[3:0] & en[3:0]) : |(m_int[7:4] & en[7:4]);
   endfunction

   // One non-pipelined transfer; ign selects a transfer the slave must ignore
   task automatic bus(input bit w, input logic [7:0] off, input logic [31:0] d,
                      input int ign, output logic [31:0] rd);
      hsel   = (ign != 1);
      htrans = (ign == 2) ? 2'b00 : 2'b10;
      hready = (ign != 3);
      hwrite = w;
      haddr  = {24'($urandom), off};
      hsize  = 3'($urandom);
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hready = 1'b1; hwrite = 1'b0; haddr = '0;
      hwdata = d;
      rd = hrdata;
      @(posedge hclk); #1;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd, e;
      bus(1'b1, off, d, 0, rd);
      e = model(1'b1, off, d);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] rd, e;
      bus(1'b0, off, 32'h0, 0, rd);
      e = model(1'b0, off, 32'h0);
      check(tag, rd, exp);
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      model_reset();
      repeat (2) @(posedge hclk);
      #1 hresetn = 1'b1;
      @(posedge hclk); #1;
   endtask

   initial begin
      logic [31:0] rd, e;
      do_reset();

      check("reset intr_0", {31'b0, intr_0}, 32'h0);
      check("reset intr_1", {31'b0, intr_1}, 32'h0);
      for (int a = 0; a <= 'h44; a += 4) begin
         rd_chk($sformatf("reset rd %02h", a), 8'(a), 32'h0);
         check("hreadyout", {31'b0, hreadyout}, 32'h1);
         check("hresp", {30'b0, hresp}, 32'h0);
      end

      wr(8'h00, 32'h1);
      rd_chk("lock sem0 stat", 8'h30, 32'h1);
      wr(8'h00, 32'hAA00);
      check("release intr_1", {31'b0, intr_1}, 32'h1);
      check("release intr_0", {31'b0, intr_0}, 32'h0);
      rd_chk("release int_stat", 8'h20, 32'h10);
      rd_chk("release err", 8'h28, 32'h0);
      rd_chk("int_clr read", 8'h24, 32'h10);

      wr(8'h00, 32'h1);
      wr(8'h04, 32'h1);
      rd_chk("contend stat", 8'h30, 32'h1);
      rd_chk("contend err", 8'h28, 32'h10);
      rd_chk("err_clr read", 8'h2C, 32'h10);
      rd_chk("err cleared", 8'h28, 32'h0);

      wr(8'h04, 32'h0);
      rd_chk("foreign release err", 8'h28, 32'h10);
      rd_chk("foreign release stat", 8'h30, 32'h1);
      wr(8'h2C, 32'h10);
      rd_chk("err_clr write", 8'h28, 32'h0);

      wr(8'h00, 32'h0);
      rd_chk("own release int", 8'h20, 32'h10);
      rd_chk("int_clr rd2", 8'h24, 32'h10);
      rd_chk("int cleared", 8'h20, 32'h0);
      check("intr_1 cleared", {31'b0, intr_1}, 32'h0);

      // Back-to-back: write 0x08 then read 0x34 in the following address phase
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1000_2008;
      @(posedge hclk); #1;
      hwdata = 32'h1; hwrite = 1'b0; haddr = 32'h1000_2034;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00;
      e = model(1'b1, 8'h08, 32'h1);
      e = model(1'b0, 8'h34, 32'h0);
      check("b2b read", hrdata, 32'h1);
      @(posedge hclk); #1;
      check("idle hrdata", hrdata, 32'h0);

      wr(8'h0C, 32'h1);
      rd_chk("core1 lock held", 8'h34, 32'h1);
      rd_chk("err bit5", 8'h28, 32'h20);

`ifdef HSEM_INT_MASK_EN
      wr(8'h40, 32'h0);
      wr(8'h08, 32'h0);
      rd_chk("masked int_stat", 8'h20, 32'h20);
      check("masked intr_1", {31'b0, intr_1}, 32'h0);
      wr(8'h40, 32'hFF);
      check("unmasked intr_1", {31'b0, intr_1}, 32'h1);
      rd_chk("int_en read", 8'h40, 32'hFF);
`else
      wr(8'h40, 32'hFF);
      rd_chk("0x40 unmapped", 8'h40, 32'h0);
`endif

      // Reset during a data phase discards the pending write
      do_reset();
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0010;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1;
      hresetn = 1'b0;
      @(posedge hclk); #1;
      hresetn = 1'b1;
      @(posedge hclk); #1;
      rd_chk("reset discards write", 8'h38, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r, ign;
         bit w;
         logic [7:0] off;
         logic [31:0] d;
         r = $urandom_range(0, 23);
         if (r < 16) off = 8'((r % 8) * 4);
         else if (r < 20) off = 8'(8'h20 + (r - 16) * 4);
         else if (r < 22) off = 8'(8'h30 + $urandom_range(0, 3) * 4);
         else if (r == 22) off = 8'h40;
         else off = {6'($urandom_range(17, 63)), 2'b00};
         w = ($urandom_range(0, 9) < 6);
         d = $urandom;
         ign = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
         bus(w, off, d, ign, rd);
         if (ign == 0) begin
            e = model(w, off, d);
            if (!w) check($sformatf("rand rd %02h", off), rd, e);
         end
         check("rand intr_0", {31'b0, intr_0}, {31'b0, exp_intr(0)});
         check("rand intr_1", {31'b0, intr_1}, {31'b0, exp_intr(1)});
      end
      for (int n = 0; n < 4; n++)
         rd_chk($sformatf("final sem%0d", n), 8'(8'h30 + n * 4), sem_word(n));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
